// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, reset/bubble defaults,
// the skid entry layout and the PC increment helper.
package if_fetch_stage_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FS_REQ  = 2'd0,
      FS_WAIT = 2'd1,
      FS_DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus, named from the fetch stage's side.
interface if_fetch_stage_if;

   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_gnt_i,
      input  imem_rvalid_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_gnt_i,
      output imem_rvalid_i,
      output imem_rdata_i
   );

endinterface

// File: rtl/if_fetch_stage_skid_buffer.sv
// One-entry holding register for a fetch response that lands while IF/ID is stalled.
module if_skid_buffer
   import if_fetch_stage_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clear_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  fetch_entry_t entry_i,
   output logic         full_o,
   output fetch_entry_t entry_o
);

   logic         full_q;
   logic         full_d;
   fetch_entry_t entry_q;
   fetch_entry_t entry_d;

   always_comb begin
      full_d  = full_q;
      entry_d = entry_q;
      if (clear_i) begin
         full_d = 1'b0;
      end else if (push_i) begin
         full_d  = 1'b1;
         entry_d = entry_i;
      end else if (pop_i) begin
         full_d = 1'b0;
      end else begin
         full_d = full_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         full_q  <= 1'b0;
         entry_q <= fetch_entry_t'(64'h0);
      end else begin
         full_q  <= full_d;
         entry_q <= entry_d;
      end
   end

   assign full_o  = full_q;
   assign entry_o = entry_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requester feeding the IF/ID register.
// Hazard inputs freeze the PC / hold IF/ID; a taken branch in ID flushes and redirects.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             PCWrite_i,
   input  logic             Stall_i,
   input  logic             Flush_i,
   input  logic [31:0]      BranchTarget_i,
   if_fetch_stage_if.master imem,
   output logic [31:0]      IF_ID_PC_o,
   output logic [31:0]      IF_ID_Instr_o,
   output logic             IF_ID_Valid_o
);

   fetch_state_e state_q;
   fetch_state_e state_d;
   logic [31:0]  pc_q;
   logic [31:0]  pc_d;
   logic [31:0]  req_pc_q;
   logic [31:0]  req_pc_d;
   logic [31:0]  if_pc_q;
   logic [31:0]  if_pc_d;
   logic [31:0]  if_instr_q;
   logic [31:0]  if_instr_d;
   logic         if_valid_q;
   logic         if_valid_d;

   logic         req_s;
   logic         fire_s;
   logic         resp_s;
   logic         skid_full_s;
   logic         skid_push_s;
   logic         skid_pop_s;
   fetch_entry_t skid_in_s;
   fetch_entry_t skid_out_s;

   // A full skid buffer means IF/ID is backed up, so no new fetch is started.
   assign req_s       = ~rst_i & (state_q == FS_REQ) & PCWrite_i & ~skid_full_s;
   assign fire_s      = req_s & imem.imem_gnt_i;
   assign resp_s      = (state_q == FS_WAIT) & imem.imem_rvalid_i & ~Flush_i;
   assign skid_push_s = resp_s & Stall_i;
   assign skid_pop_s  = skid_full_s & ~Stall_i & ~Flush_i;

   assign skid_in_s.instr = imem.imem_rdata_i;
   assign skid_in_s.pc    = req_pc_q;

   assign imem.imem_req_o  = req_s;
   assign imem.imem_addr_o = pc_q;

   if_skid_buffer u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (Flush_i),
      .push_i  (skid_push_s),
      .pop_i   (skid_pop_s),
      .entry_i (skid_in_s),
      .full_o  (skid_full_s),
      .entry_o (skid_out_s)
   );

   // A flush during an in-flight fetch parks in DROP until the stale response drains.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FS_REQ: begin
            if (fire_s) begin
               state_d = Flush_i ? FS_DROP : FS_WAIT;
            end else begin
               state_d = FS_REQ;
            end
         end
         FS_WAIT: begin
            if (imem.imem_rvalid_i) begin
               state_d = FS_REQ;
            end else if (Flush_i) begin
               state_d = FS_DROP;
            end else begin
               state_d = FS_WAIT;
            end
         end
         FS_DROP: begin
            if (imem.imem_rvalid_i) begin
               state_d = FS_REQ;
            end else begin
               state_d = FS_DROP;
            end
         end
         default: state_d = FS_REQ;
      endcase
   end

   always_comb begin
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      if (Flush_i) begin
         pc_d = BranchTarget_i;
      end else if (fire_s) begin
         pc_d = pc_inc(pc_q);
      end else begin
         pc_d = pc_q;
      end
      if (fire_s) begin
         req_pc_d = pc_q;
      end else begin
         req_pc_d = req_pc_q;
      end
   end

   // The skid entry is older than any live response, so it drains first.
   always_comb begin
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      if_valid_d = if_valid_q;
      if (Flush_i) begin
         if_instr_d = NOP_INSTR;
         if_valid_d = 1'b0;
      end else if (Stall_i) begin
         if_valid_d = if_valid_q;
      end else if (skid_full_s) begin
         if_pc_d    = skid_out_s.pc;
         if_instr_d = skid_out_s.instr;
         if_valid_d = 1'b1;
      end else if (resp_s) begin
         if_pc_d    = req_pc_q;
         if_instr_d = imem.imem_rdata_i;
         if_valid_d = 1'b1;
      end else begin
         if_instr_d = NOP_INSTR;
         if_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= FS_REQ;
         pc_q       <= RESET_PC;
         req_pc_q   <= RESET_PC;
         if_pc_q    <= 32'h0000_0000;
         if_instr_q <= NOP_INSTR;
         if_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         if_valid_q <= if_valid_d;
      end
   end

   assign IF_ID_PC_o    = if_pc_q;
   assign IF_ID_Instr_o = if_instr_q;
   assign IF_ID_Valid_o = if_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized hazards
// and memory timing, checked against a program-order fetch stream model.
module tb_if_fetch_stage;
   import if_fetch_stage_pkg::*;

   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        pcwrite;
   logic        stall;
   logic        flush;
   logic [31:0] target;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        ifid_valid;
   logic [31:0] w_pc;
   logic [31:0] w_instr;
   logic        w_valid;

   if_fetch_stage_if bus ();
   if_fetch_stage_if wbus ();

   int          n_vec = 0;
   int          n_err = 0;
   int          deliveries = 0;

   // Reference model state: next fetch address, next expected delivery, memory.
   logic [31:0] fetch_pc;
   logic [31:0] exp_pc;
   logic [31:0] mem_addr;
   bit          mem_busy;
   int          mem_cnt;
   bit          w_busy;
   int          lat_min = 1;
   int          lat_max = 1;
   bit          gnt_always = 1'b1;
   bit          expect_req_low = 1'b0;
   bit          expect_req_high = 1'b0;

   always #5 clk = ~clk;

   if_fetch_stage u_dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .PCWrite_i      (pcwrite),
      .Stall_i        (stall),
      .Flush_i        (flush),
      .BranchTarget_i (target),
      .imem           (bus),
      .IF_ID_PC_o     (ifid_pc),
      .IF_ID_Instr_o  (ifid_instr),
      .IF_ID_Valid_o  (ifid_valid)
   );

   if_fetch_stage #(.RESET_PC(WRAP_PC)) u_dut_wrap (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .PCWrite_i      (1'b1),
      .Stall_i        (1'b0),
      .Flush_i        (1'b0),
      .BranchTarget_i (32'h0000_0000),
      .imem           (wbus),
      .IF_ID_PC_o     (w_pc),
      .IF_ID_Instr_o  (w_instr),
      .IF_ID_Valid_o  (w_valid)
   );

   function automatic logic [31:0] word_for(input logic [31:0] a);
      if (a == 32'h0000_0000) return 32'h00A0_0093;
      else if (a == 32'h0000_0004) return 32'h0010_0113;
      else return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_i   = 1'b1;
      stall   = 1'b0;
      pcwrite = 1'b1;
      flush   = 1'b0;
      target  = 32'h0;
      bus.imem_gnt_i    = 1'b1;
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = 32'hBAD0_BAD0;
      wbus.imem_gnt_i   = 1'b1;
      wbus.imem_rvalid_i = 1'b0;
      wbus.imem_rdata_i = 32'h0;
      mem_busy = 1'b0;
      w_busy   = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check_val("rst_req", 32'(bus.imem_req_o), 32'd0);
         @(posedge clk);
         #1;
      end
      check_val("rst_ifid_pc", ifid_pc, 32'h0);
      check_val("rst_ifid_instr", ifid_instr, NOP);
      check_val("rst_ifid_valid", 32'(ifid_valid), 32'd0);
      rst_i = 1'b0;
      bus.imem_rvalid_i = 1'b0;
      fetch_pc = 32'h0;
      exp_pc   = 32'h0;
   endtask

   task automatic run_cycle(input bit st, input bit pw, input bit fl, input logic [31:0] tgt);
      bit          fire;
      bit          rv;
      bit          w_fire;
      logic [31:0] addr_s;
      logic [31:0] pc_prev;
      logic [31:0] instr_prev;
      logic        v_prev;
      stall   = st;
      pcwrite = pw;
      flush   = fl;
      target  = tgt;
      bus.imem_gnt_i = gnt_always ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (mem_busy) begin
         mem_cnt--;
         bus.imem_rvalid_i = (mem_cnt == 0);
      end else begin
         bus.imem_rvalid_i = 1'b0;
      end
      bus.imem_rdata_i   = bus.imem_rvalid_i ? word_for(mem_addr) : 32'hDEAD_BEEF;
      wbus.imem_gnt_i    = 1'b1;
      wbus.imem_rvalid_i = w_busy;
      wbus.imem_rdata_i  = word_for(WRAP_PC);
      @(negedge clk);
      if (mem_busy || !pw) check_val("req_low", 32'(bus.imem_req_o), 32'd0);
      if (expect_req_low) check_val("skid_req_low", 32'(bus.imem_req_o), 32'd0);
      if (expect_req_high) check_val("req_high", 32'(bus.imem_req_o), 32'd1);
      if (bus.imem_req_o) check_val("fetch_addr", bus.imem_addr_o, fetch_pc);
      fire       = bus.imem_req_o && bus.imem_gnt_i;
      rv         = bus.imem_rvalid_i;
      addr_s     = bus.imem_addr_o;
      w_fire     = wbus.imem_req_o && wbus.imem_gnt_i;
      pc_prev    = ifid_pc;
      instr_prev = ifid_instr;
      v_prev     = ifid_valid;
      @(posedge clk);
      #1;
      if (rv) mem_busy = 1'b0;
      if (fire) begin
         mem_busy = 1'b1;
         mem_addr = addr_s;
         mem_cnt  = $urandom_range(lat_max, lat_min);
      end
      w_busy = w_fire;
      if (fl) begin
         fetch_pc = tgt;
         exp_pc   = tgt;
         check_val("flush_instr", ifid_instr, NOP);
         check_val("flush_valid", 32'(ifid_valid), 32'd0);
      end else begin
         if (fire) fetch_pc = fetch_pc + 32'd4;
         if (st) begin
            check_val("hold_pc", ifid_pc, pc_prev);
            check_val("hold_instr", ifid_instr, instr_prev);
            check_val("hold_valid", 32'(ifid_valid), 32'(v_prev));
         end else if (ifid_valid) begin
            check_val("stream_pc", ifid_pc, exp_pc);
            check_val("stream_instr", ifid_instr, word_for(exp_pc));
            exp_pc = exp_pc + 32'd4;
            deliveries++;
         end else begin
            check_val("bubble_instr", ifid_instr, NOP);
         end
      end
   endtask

   initial begin
      logic [31:0] r;
      bit          st;
      bit          pw;
      bit          fl;
      logic [31:0] tgt;

      // Back-to-back fetches, 1-cycle latency; wrap instance starts at 0xFFFF_FFFC.
      do_reset();
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check_val("wrap_addr", wbus.imem_addr_o, 32'h0);
      check_val("wrap_wait_req", 32'(wbus.imem_req_o), 32'd0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check_val("first_pc", ifid_pc, 32'h0);
      check_val("first_instr", ifid_instr, 32'h00A0_0093);
      check_val("first_valid", 32'(ifid_valid), 32'd1);
      check_val("wrap_ifid_pc", w_pc, WRAP_PC);
      check_val("wrap_next_addr", wbus.imem_addr_o, 32'h0);
      check_val("wrap_next_req", 32'(wbus.imem_req_o), 32'd1);
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check_val("second_pc", ifid_pc, 32'h4);
      check_val("second_instr", ifid_instr, 32'h0010_0113);

      // Response lands under stall; skid holds it until release.
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      expect_req_low = 1'b1;
      run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      expect_req_low = 1'b0;
      check_val("skid_out_pc", ifid_pc, 32'h8);
      check_val("skid_out_valid", 32'(ifid_valid), 32'd1);
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);

      // Flush together with stall and frozen PC, while the skid is full.
      run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      run_cycle(1'b1, 1'b0, 1'b1, 32'h0000_0200);
      expect_req_high = 1'b1;
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      expect_req_high = 1'b0;
      repeat (6) run_cycle(1'b0, 1'b1, 1'b0, 32'h0);

      // Flush while waiting on a 2-cycle response: stale data dropped, redirect to 0x100.
      lat_min = 2;
      lat_max = 2;
      do_reset();
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      run_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0100);
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      expect_req_high = 1'b1;
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      expect_req_high = 1'b0;
      repeat (8) run_cycle(1'b0, 1'b1, 1'b0, 32'h0);

      // Randomized hazards, grants, latencies and branch targets.
      lat_min    = 1;
      lat_max    = 3;
      gnt_always = 1'b0;
      deliveries = 0;
      for (int i = 0; i < 3000; i++) begin
         st  = ($urandom_range(0, 3) == 0);
         pw  = st ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) != 0);
         fl  = ($urandom_range(0, 15) == 0);
         r   = $urandom();
         tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : {r[31:2], 2'b00};
         run_cycle(st, pw, fl, tgt);
      end
      check_val("liveness", 32'(deliveries >= 100), 32'd1);

      // Reset while a 3-cycle fetch is outstanding.
      gnt_always = 1'b1;
      lat_min    = 3;
      lat_max    = 3;
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      do_reset();
      #1;
      check_val("post_rst_req", 32'(bus.imem_req_o), 32'd1);
      check_val("post_rst_addr", bus.imem_addr_o, 32'h0);
      lat_min = 1;
      lat_max = 1;
      repeat (6) run_cycle(1'b0, 1'b1, 1'b0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
